// File: rtl/csr_file_pkg.sv
// Shared types and constants for the machine-mode CSR file.
//   common : word_t, the 64-bit machine word.
//   pipes  : CSR operation encoding, CSR addresses, mstatus writable mask,
//            privilege encodings and mstatus field positions.
package common;
  typedef logic [63:0] word_t;
endpackage

package pipes;
  // Encoding follows the low two bits of the CSR funct3 field.
  typedef enum logic [1:0] {
    CSR_NOP = 2'b00,
    CSR_W   = 2'b01,
    CSR_S   = 2'b10,
    CSR_C   = 2'b11
  } csr_op_t;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  localparam logic [63:0] MSTATUS_MASK = 64'h0000_0000_0000_1888;

  localparam logic [1:0] PRIV_M = 2'b11;
  localparam logic [1:0] PRIV_U = 2'b00;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MPP_LO   = 11;
  localparam int MPP_HI   = 12;
endpackage

// File: rtl/csr_file_alu.sv
// csr_alu: combinational read-modify-write for CSR instructions.
//   o    : current register value
//   wd   : write operand
//   wop  : CSR_W / CSR_S / CSR_C
//   mask : writable bits of the target register
//   nv   : new value, already masked
module csr_alu
  import common::*;
  import pipes::*;
(
  input  word_t   o,
  input  word_t   wd,
  input  csr_op_t wop,
  input  word_t   mask,
  output word_t   nv
);
  word_t comb;

  always_comb begin
    comb = o;
    case (wop)
      CSR_W:   comb = wd;
      CSR_S:   comb = o | wd;
      CSR_C:   comb = o & ~wd;
      default: comb = o;
    endcase
  end

  // Non-writable bits of every implemented CSR hold zero, so masking is enough.
  assign nv = comb & mask;
endmodule

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file for the RV64 pipeline.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   ra -> rd, rd_illegal          combinational CSR read for execute
//   we, wa, wop, wd               committed CSR write from writeback
//   trap_valid/cause/pc/tval      trap entry
//   mret                          mret commit
//   redirect_valid, redirect_pc   registered one-cycle redirect to fetch
//   priv                          current privilege level
// Build option: CSR_FWD_EN enables same-cycle bypass of the committing
// write / trap / mret onto rd; without it rd always shows pre-edge state.
module csr_file
  import common::*;
  import pipes::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] ra,
  output word_t       rd,
  output logic        rd_illegal,
  input  logic        we,
  input  logic [11:0] wa,
  input  csr_op_t     wop,
  input  word_t       wd,
  input  logic        trap_valid,
  input  word_t       trap_cause,
  input  word_t       trap_pc,
  input  word_t       trap_tval,
  input  logic        mret,
  output logic        redirect_valid,
  output word_t       redirect_pc,
  output logic [1:0]  priv
);
  word_t mstatus, mtvec, mepc, mcause, mtval, mscratch, mie, mcycle;
  word_t rd_raw, wold, wmask, nv, mstatus_evt, tvec_base, trap_target;
  logic  wlegal, write_en;

  // Read port.
  always_comb begin
    rd_raw     = '0;
    rd_illegal = 1'b0;
    case (ra)
      CSR_MSTATUS:  rd_raw = mstatus;
      CSR_MTVEC:    rd_raw = mtvec;
      CSR_MEPC:     rd_raw = mepc;
      CSR_MCAUSE:   rd_raw = mcause;
      CSR_MTVAL:    rd_raw = mtval;
      CSR_MSCRATCH: rd_raw = mscratch;
      CSR_MIE:      rd_raw = mie;
      CSR_MCYCLE:   rd_raw = mcycle;
      CSR_MHARTID:  rd_raw = '0;
      default:      rd_illegal = 1'b1;
    endcase
  end

  // Old value and writable mask of the write target; mhartid is read-only.
  always_comb begin
    wold   = '0;
    wmask  = '1;
    wlegal = 1'b1;
    case (wa)
      CSR_MSTATUS:  begin wold = mstatus; wmask = MSTATUS_MASK; end
      CSR_MTVEC:    wold = mtvec;
      CSR_MEPC:     begin wold = mepc; wmask = ~64'h3; end
      CSR_MCAUSE:   wold = mcause;
      CSR_MTVAL:    wold = mtval;
      CSR_MSCRATCH: wold = mscratch;
      CSR_MIE:      wold = mie;
      CSR_MCYCLE:   wold = mcycle;
      default:      wlegal = 1'b0;
    endcase
  end

  csr_alu u_alu (
    .o    (wold),
    .wd   (wd),
    .wop  (wop),
    .mask (wmask),
    .nv   (nv)
  );

  // A trap or mret drops the write outright.
  assign write_en = we && wlegal && !trap_valid && !mret;

  // mstatus after the committing trap or mret this cycle.
  always_comb begin
    mstatus_evt = mstatus;
    if (trap_valid) begin
      mstatus_evt[MPIE_BIT]       = mstatus[MIE_BIT];
      mstatus_evt[MIE_BIT]        = 1'b0;
      mstatus_evt[MPP_HI:MPP_LO]  = priv;
    end else if (mret) begin
      mstatus_evt[MIE_BIT]        = mstatus[MPIE_BIT];
      mstatus_evt[MPIE_BIT]       = 1'b1;
      mstatus_evt[MPP_HI:MPP_LO]  = PRIV_U;
    end
  end

  // Vectored mode applies only to interrupts; the shift discards cause bit 62.
  assign tvec_base   = {mtvec[63:2], 2'b00};
  assign trap_target = (mtvec[1:0] == 2'b01 && trap_cause[63])
                     ? tvec_base + ({1'b0, trap_cause[62:0]} << 2)
                     : tvec_base;

`ifdef CSR_FWD_EN
  always_comb begin
    if ((trap_valid || mret) && ra == CSR_MSTATUS) rd = mstatus_evt;
    else if (write_en && wa == ra)                 rd = nv;
    else                                           rd = rd_raw;
  end
`else
  assign rd = rd_raw;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      mstatus        <= '0;
      mtvec          <= '0;
      mepc           <= '0;
      mcause         <= '0;
      mtval          <= '0;
      mscratch       <= '0;
      mie            <= '0;
      mcycle         <= '0;
      priv           <= PRIV_M;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      mcycle         <= mcycle + 64'd1;
      redirect_valid <= 1'b0;
      if (trap_valid) begin
        mepc           <= trap_pc & ~64'h3;
        mcause         <= trap_cause;
        mtval          <= trap_tval;
        mstatus        <= mstatus_evt;
        priv           <= PRIV_M;
        redirect_valid <= 1'b1;
        redirect_pc    <= trap_target;
      end else if (mret) begin
        mstatus        <= mstatus_evt;
        priv           <= mstatus[MPP_HI:MPP_LO];
        redirect_valid <= 1'b1;
        redirect_pc    <= mepc;
      end else if (write_en) begin
        case (wa)
          CSR_MSTATUS:  mstatus  <= nv;
          CSR_MTVEC:    mtvec    <= nv;
          CSR_MEPC:     mepc     <= nv;
          CSR_MCAUSE:   mcause   <= nv;
          CSR_MTVAL:    mtval    <= nv;
          CSR_MSCRATCH: mscratch <= nv;
          CSR_MIE:      mie      <= nv;
          CSR_MCYCLE:   mcycle   <= nv;
          default:      ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_csr_file.sv
module tb_csr_file;
  import common::*;
  import pipes::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] ra, wa;
  word_t       rd, wd, trap_cause, trap_pc, trap_tval, redirect_pc;
  logic        rd_illegal, we, trap_valid, mret, redirect_valid;
  csr_op_t     wop;
  logic [1:0]  priv;

  int checks = 0;
  int errors = 0;

  csr_file dut (
    .clk            (clk),
    .reset          (reset),
    .ra             (ra),
    .rd             (rd),
    .rd_illegal     (rd_illegal),
    .we             (we),
    .wa             (wa),
    .wop            (wop),
    .wd             (wd),
    .trap_valid     (trap_valid),
    .trap_cause     (trap_cause),
    .trap_pc        (trap_pc),
    .trap_tval      (trap_tval),
    .mret           (mret),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .priv           (priv)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] wa;
    csr_op_t     wop;
    word_t       wd;
    logic [11:0] ra;
    word_t       exp_rd;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[13];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic read_check(input string name, input logic [11:0] a, input word_t exp);
    ra = a;
    #1;
    check(name, rd, exp);
  endtask

  task automatic clear_events();
    we = 1'b0; trap_valid = 1'b0; mret = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{CSR_MSCRATCH, CSR_W, 64'hF0F0,             CSR_MSCRATCH, 64'hF0F0,             1'b0};
    vecs[1]  = '{CSR_MSCRATCH, CSR_S, 64'h000F,             CSR_MSCRATCH, 64'hF0FF,             1'b0};
    vecs[2]  = '{CSR_MSCRATCH, CSR_C, 64'h00F0,             CSR_MSCRATCH, 64'hF00F,             1'b0};
    vecs[3]  = '{CSR_MSTATUS,  CSR_W, 64'hFFFF_FFFF_FFFF_FFFF, CSR_MSTATUS, 64'h1888,           1'b0};
    vecs[4]  = '{CSR_MEPC,     CSR_W, 64'h8000_0013,        CSR_MEPC,     64'h8000_0010,        1'b0};
    vecs[5]  = '{CSR_MHARTID,  CSR_W, 64'hFFFF,             CSR_MHARTID,  64'h0,                1'b0};
    vecs[6]  = '{12'h7C0,      CSR_W, 64'h1234,             12'h7C0,      64'h0,                1'b1};
    vecs[7]  = '{CSR_MIE,      CSR_W, 64'hAA,               CSR_MIE,      64'hAA,               1'b0};
    vecs[8]  = '{CSR_MSTATUS,  CSR_C, 64'h1880,             CSR_MSTATUS,  64'h0008,             1'b0};
    vecs[9]  = '{CSR_MTVEC,    CSR_W, 64'h1001,             CSR_MTVEC,    64'h1001,             1'b0};
    vecs[10] = '{CSR_MCAUSE,   CSR_S, 64'h5,                CSR_MCAUSE,   64'h5,                1'b0};
    vecs[11] = '{CSR_MTVAL,    CSR_W, 64'h77,               CSR_MTVAL,    64'h77,               1'b0};
    vecs[12] = '{CSR_MCYCLE,   CSR_W, 64'd100,              CSR_MCYCLE,   64'd100,              1'b0};

    reset = 1'b1; ra = '0; wa = '0; wop = CSR_W; wd = '0;
    trap_cause = '0; trap_pc = '0; trap_tval = '0;
    clear_events();
    step();
    reset = 1'b0;

    // Reset state
    read_check("rst_mstatus", CSR_MSTATUS, 64'h0);
    read_check("rst_mtvec", CSR_MTVEC, 64'h0);
    read_check("rst_mepc", CSR_MEPC, 64'h0);
    check("rst_priv", {62'd0, priv}, 64'd3);
    check("rst_redirect_valid", {63'd0, redirect_valid}, 64'd0);
    step(); step(); step();
    read_check("rst_mcycle", CSR_MCYCLE, 64'd3);

    // Same-cycle write and read of mscratch (old value is 0)
    we = 1'b1; wa = CSR_MSCRATCH; wop = CSR_W; wd = 64'h55;
`ifdef CSR_FWD_EN
    read_check("fwd_mscratch", CSR_MSCRATCH, 64'h55);
`else
    read_check("nofwd_mscratch", CSR_MSCRATCH, 64'h0);
`endif
    step();
    clear_events();
    read_check("mscratch_after_fwd_write", CSR_MSCRATCH, 64'h55);

    // Table of write-then-read vectors
    for (int i = 0; i < 13; i++) begin
      we = 1'b1; wa = vecs[i].wa; wop = vecs[i].wop; wd = vecs[i].wd;
      step();
      we = 1'b0;
      ra = vecs[i].ra;
      #1;
      check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_ill", i), {63'd0, rd_illegal}, {63'd0, vecs[i].exp_ill});
    end
    step();
    read_check("mcycle_plus1", CSR_MCYCLE, 64'd101);

    // Vectored interrupt with mret and write in the same cycle
    trap_valid = 1'b1; trap_cause = 64'h8000_0000_0000_0007;
    trap_pc = 64'h8000_0010; trap_tval = 64'h33;
    mret = 1'b1; we = 1'b1; wa = CSR_MSCRATCH; wop = CSR_W; wd = 64'd5;
    step();
    clear_events();
    check("trap_rv", {63'd0, redirect_valid}, 64'd1);
    check("trap_rpc", redirect_pc, 64'h101C);
    check("trap_priv", {62'd0, priv}, 64'd3);
    read_check("trap_mepc", CSR_MEPC, 64'h8000_0010);
    read_check("trap_mstatus", CSR_MSTATUS, 64'h1880);
    read_check("trap_mscratch", CSR_MSCRATCH, 64'hF00F);
    read_check("trap_mcause", CSR_MCAUSE, 64'h8000_0000_0000_0007);
    read_check("trap_mtval", CSR_MTVAL, 64'h33);
    step();
    check("pulse_end_rv", {63'd0, redirect_valid}, 64'd0);
    check("pulse_end_hold_pc", redirect_pc, 64'h101C);

    // mret with a dropped write
    mret = 1'b1; we = 1'b1; wa = CSR_MSCRATCH; wd = 64'd9;
    step();
    clear_events();
    check("mret_rv", {63'd0, redirect_valid}, 64'd1);
    check("mret_rpc", redirect_pc, 64'h8000_0010);
    check("mret_priv", {62'd0, priv}, 64'd3);
    read_check("mret_mstatus", CSR_MSTATUS, 64'h88);
    read_check("mret_mscratch", CSR_MSCRATCH, 64'hF00F);

    // Second mret drops to U (MPP was cleared)
    mret = 1'b1;
    step();
    clear_events();
    check("mret2_priv", {62'd0, priv}, 64'd0);
    read_check("mret2_mstatus", CSR_MSTATUS, 64'h88);

    // Direct-mode trap from U
    we = 1'b1; wa = CSR_MTVEC; wop = CSR_W; wd = 64'h2000;
    step();
    clear_events();
    trap_valid = 1'b1; trap_cause = 64'h8000_0000_0000_0003; trap_pc = 64'h44; trap_tval = '0;
    step();
    clear_events();
    check("utrap_rv", {63'd0, redirect_valid}, 64'd1);
    check("utrap_rpc", redirect_pc, 64'h2000);
    check("utrap_priv", {62'd0, priv}, 64'd3);
    read_check("utrap_mstatus", CSR_MSTATUS, 64'h80);
    read_check("utrap_mepc", CSR_MEPC, 64'h44);

    // mcycle wrap
    we = 1'b1; wa = CSR_MCYCLE; wop = CSR_W; wd = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    clear_events();
    read_check("mcycle_max", CSR_MCYCLE, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    read_check("mcycle_wrap", CSR_MCYCLE, 64'h0);

    // Reset cancels a pending redirect and overrides trap and write
    trap_valid = 1'b1; trap_cause = 64'h2; trap_pc = 64'h100;
    step();
    check("pre_reset_rv", {63'd0, redirect_valid}, 64'd1);
    reset = 1'b1; we = 1'b1; wa = CSR_MSCRATCH; wop = CSR_W; wd = 64'h99;
    step();
    reset = 1'b0;
    clear_events();
    check("reset_rv", {63'd0, redirect_valid}, 64'd0);
    check("reset_rpc", redirect_pc, 64'h0);
    check("reset_priv", {62'd0, priv}, 64'd3);
    read_check("reset_mscratch", CSR_MSCRATCH, 64'h0);
    read_check("reset_mepc", CSR_MEPC, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
